mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; memory holds 2**ADDR_W 16-bit words.
REQ-002 Parameter IO_BASE, default 16'hFF00, byte base address of the I/O window 16'hFF00-16'hFFFF.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 i_addr  input  16  CPU instruction byte address.
REQ-006 i_oe  input  1  CPU instruction read enable.
REQ-007 i_din  output  16  instruction word returned to the CPU.
REQ-008 d_addr  input  16  CPU data byte address.
REQ-009 d_oe  input  1  CPU data read enable.
REQ-010 d_dout  input  16  CPU write data; byte lanes pre-positioned by the CPU.
REQ-011 d_we  input  2  byte write enables; d_we[0] selects bits [15:8] (even byte), d_we[1] selects bits [7:0] (odd byte).
REQ-012 d_din  output  16  data word returned to the CPU.
REQ-013 ld_start  input  1  host request to begin a program load.
REQ-014 ld_valid  input  1  host load word valid.
REQ-015 ld_data  input  16  host load word.
REQ-016 ld_last  input  1  marks the final load word.
REQ-017 ld_ready  output  1  block accepts a load word.
REQ-018 cpu_rst  output  1  active-high synchronous reset driven to the CPU.
REQ-019 gpio_out  output  16  CPU-writable output register.

Function
REQ-020 FSM states: IDLE, LOAD, RUN. IDLE->LOAD on ld_start; LOAD->RUN on the accepted word with ld_last=1, or on the accepted word at word address 2**ADDR_W-1; RUN->LOAD on ld_start.
REQ-021 ld_start in IDLE or RUN also clears the load word counter to 0; ld_start in LOAD is ignored.
REQ-022 ld_ready = 1 only in LOAD; a word is accepted when ld_valid && ld_ready, is written to mem[counter], and the counter increments by 1.
REQ-023 cpu_rst = 1 in IDLE and LOAD, plus the first RUN cycle; it is 0 from the second RUN cycle onward.
REQ-024 Memory word index = addr[ADDR_W:1]; higher address bits are ignored (aliasing) outside the I/O window.
REQ-025 Reads are combinational: i_din = mem[i_addr] when i_oe, else 0; d_din = the addressed word when d_oe, else 0.
REQ-026 CPU writes are applied at the clock edge, per byte lane from d_we; they are honored only in RUN with cpu_rst = 0.
REQ-027 Same-cycle write and read to one address returns the old contents; the new value is visible next cycle.
REQ-028 I/O 16'hFF00 = gpio register: readable, byte-writable.
REQ-029 I/O 16'hFF02 = 16-bit cycle counter; increments every cycle in RUN and wraps 16'hFFFF->0; any CPU write clears it to 0, and the write takes priority over the increment.
REQ-030 Other I/O addresses read 0 and ignore writes; I/O accesses never touch the memory array.
REQ-031 The cycle counter is cleared on entry to LOAD; gpio_out holds its value across loads.

Reset
REQ-032 On rst = 0 the block enters IDLE: cpu_rst = 1, ld_ready = 0, gpio_out = 0, cycle counter = 0, load counter = 0.
REQ-033 Memory contents are not reset.
REQ-034 Reset asserted mid-load abandons the load; words already written remain.

Structure
REQ-035 A shared package risc16_pkg holds the FSM state enum, IO_BASE, and the I/O register offsets.
REQ-036 The memory array is one sub-module, dpram16: two combinational read ports, one write port with 2 byte enables. The loader and the CPU share its write port through a mux selected by state.

Verification
REQ-037 Reset, ld_start, then words 16'h1111, 16'h2222, 16'h3333 (last) -> mem[0..2] hold those values; ld_ready drops after the 3rd word; cpu_rst falls 2 cycles after the last accept.
REQ-038 In RUN: d_addr=16'h0004, d_dout=16'hAB00, d_we=2'b01 -> word 2 = 16'hAB33; then d_addr=16'h0005, d_dout=16'h00CD, d_we=2'b10 -> word 2 = 16'hABCD.
REQ-039 Write 16'h0000 then read 16'hFF02 for 3 cycles -> reads 0, 1, 2; at counter 16'hFFFF the next value is 0.
REQ-040 Write 16'h00A5 to 16'hFF00 -> gpio_out = 16'h00A5; memory word 0 is unchanged; a read of 16'hFF06 returns 0.
REQ-041 CPU write with cpu_rst = 1 (in LOAD) -> memory unchanged; ld_start in RUN -> cpu_rst = 1 and the cycle counter = 0 on the next cycle.
REQ-042 Load with ADDR_W=2 and 5 words, none marked last -> auto-transition to RUN after 4 words; the 5th word is not accepted.

Source files
------------

// File: rtl/risc16_pkg.sv
// risc16_pkg: shared FSM state type and I/O window layout for the memory responder.
package risc16_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    localparam logic [15:0] IO_BASE = 16'hFF00;
    localparam logic [7:0]  IO_GPIO = 8'h00;
    localparam logic [7:0]  IO_CYC  = 8'h02;
endpackage

// File: rtl/dpram16.sv
// dpram16: 16-bit word memory with two combinational read ports and one byte-enabled write port.
module dpram16 #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] ra_addr,
    output logic [15:0]   ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [15:0]   rb_data,
    input  logic [AW-1:0] w_addr,
    input  logic [15:0]   w_data,
    input  logic [1:0]    w_be
);
    logic [15:0] mem [0:(1<<AW)-1];

    // Lane 0 is the even (high) byte, lane 1 the odd (low) byte.
    always_ff @(posedge clk) begin
        if (w_be[0]) mem[w_addr][15:8] <= w_data[15:8];
        if (w_be[1]) mem[w_addr][7:0]  <= w_data[7:0];
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: program loader, CPU instruction/data memory and small I/O window
// (gpio register and free-running cycle counter) behind an IDLE/LOAD/RUN controller.
module mem_responder import risc16_pkg::*; #(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] IO_BASE = risc16_pkg::IO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_addr,
    input  logic        i_oe,
    output logic [15:0] i_din,
    input  logic [15:0] d_addr,
    input  logic        d_oe,
    input  logic [15:0] d_dout,
    input  logic [1:0]  d_we,
    output logic [15:0] d_din,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_rst,
    output logic [15:0] gpio_out
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic [15:0]       gpio_q, gpio_d, cyc_q, cyc_d;
    logic              accept, d_io, io_gpio, io_cyc, cpu_wr, gpio_wr, load_entry;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_data, mem_i, mem_d, io_rd;
    logic [1:0]        w_be;
    logic              unused_bits;

    assign unused_bits = ^{i_addr[15:ADDR_W+1], i_addr[0], d_addr[0]};
    assign ld_ready    = state_q == LOAD;
    assign accept      = ld_valid && ld_ready;
    assign d_io        = d_addr[15:8] == IO_BASE[15:8];
    assign io_gpio     = d_io && d_addr[7:1] == IO_GPIO[7:1];
    assign io_cyc      = d_io && d_addr[7:1] == IO_CYC[7:1];
    assign cpu_wr      = state_q == RUN && !cpu_rst_q && |d_we;
    assign gpio_wr     = cpu_wr && io_gpio;

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        if (ld_start && state_q != LOAD) begin
            state_d  = LOAD;
            ld_cnt_d = '0;
        end else if (accept) begin
            ld_cnt_d = ld_cnt_q + ADDR_W'(1);
            if (ld_last || ld_cnt_q == '1) state_d = RUN;
        end
        load_entry = state_d == LOAD && state_q != LOAD;
        // Held high through the first RUN cycle so the CPU leaves reset one cycle after the load ends.
        cpu_rst_d  = state_d != RUN || state_q != RUN;
        gpio_d     = {gpio_wr && d_we[0] ? d_dout[15:8] : gpio_q[15:8],
                      gpio_wr && d_we[1] ? d_dout[7:0]  : gpio_q[7:0]};
        cyc_d      = load_entry || (cpu_wr && io_cyc) ? 16'd0 :
                     state_q == RUN ? cyc_q + 16'd1 : cyc_q;
        w_addr     = ld_ready ? ld_cnt_q : d_addr[ADDR_W:1];
        w_data     = ld_ready ? ld_data : d_dout;
        w_be       = ld_ready ? {2{accept}} : (cpu_wr && !d_io ? d_we : 2'b00);
        io_rd      = io_gpio ? gpio_q : io_cyc ? cyc_q : 16'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ld_cnt_q  <= '0;
            cpu_rst_q <= 1'b1;
            gpio_q    <= '0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            cpu_rst_q <= cpu_rst_d;
            gpio_q    <= gpio_d;
            cyc_q     <= cyc_d;
        end
    end

    dpram16 #(.AW(ADDR_W)) u_ram (
        .clk     (clk),
        .ra_addr (i_addr[ADDR_W:1]),
        .ra_data (mem_i),
        .rb_addr (d_addr[ADDR_W:1]),
        .rb_data (mem_d),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .w_be    (w_be)
    );

    assign i_din    = i_oe ? mem_i : 16'd0;
    assign d_din    = !d_oe ? 16'd0 : d_io ? io_rd : mem_d;
    assign cpu_rst  = cpu_rst_q;
    assign gpio_out = gpio_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus with a read-response scoreboard for mem_responder.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_addr, i_din, d_addr, d_dout, d_din, ld_data, gpio_out;
    logic        i_oe, d_oe, ld_start, ld_valid, ld_last, ld_ready, cpu_rst;
    logic [1:0]  d_we;

    logic [15:0] s_i_addr, s_i_din, s_d_din, s_ld_data, s_gpio_out;
    logic        s_i_oe, s_ld_start, s_ld_valid, s_ld_ready, s_cpu_rst;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t        dq[$];
    exp_t        iq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] wv[3] = '{16'h1111, 16'h2222, 16'h3333};

    always #5 clk = ~clk;

    mem_responder dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
        .d_addr(d_addr), .d_oe(d_oe), .d_dout(d_dout), .d_we(d_we), .d_din(d_din),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .cpu_rst(cpu_rst), .gpio_out(gpio_out)
    );

    mem_responder #(.ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .i_addr(s_i_addr), .i_oe(s_i_oe), .i_din(s_i_din),
        .d_addr(16'h0000), .d_oe(1'b0), .d_dout(16'h0000), .d_we(2'b00), .d_din(s_d_din),
        .ld_start(s_ld_start), .ld_valid(s_ld_valid), .ld_data(s_ld_data), .ld_last(1'b0),
        .ld_ready(s_ld_ready), .cpu_rst(s_cpu_rst), .gpio_out(s_gpio_out)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (d_oe) begin
            if (dq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL d_unexpected: got %h expected no read", d_din);
            end else begin
                exp_t e;
                e = dq.pop_front();
                chk(e.name, d_din, e.exp);
            end
        end
        if (i_oe) begin
            if (iq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL i_unexpected: got %h expected no read", i_din);
            end else begin
                exp_t e;
                e = iq.pop_front();
                chk(e.name, i_din, e.exp);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_i(input string n, input logic [15:0] a, input logic [15:0] e);
        i_addr = a;
        i_oe   = 1'b1;
        iq.push_back('{n, e});
        tick();
        i_oe = 1'b0;
    endtask

    task automatic rd_d(input string n, input logic [15:0] a, input logic [15:0] e);
        d_addr = a;
        d_oe   = 1'b1;
        dq.push_back('{n, e});
        tick();
        d_oe = 1'b0;
    endtask

    task automatic wr_d(input logic [15:0] a, input logic [15:0] dat, input logic [1:0] we);
        d_addr = a;
        d_dout = dat;
        d_we   = we;
        tick();
        d_we = 2'b00;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        rst = 1'b0; i_addr = '0; i_oe = 1'b0; d_addr = '0; d_oe = 1'b0; d_dout = '0; d_we = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        s_i_addr = '0; s_i_oe = 1'b0; s_ld_start = 1'b0; s_ld_valid = 1'b0; s_ld_data = '0;
        repeat (2) tick();
        chk("rst_cpu_rst", 16'(cpu_rst), 16'd1);
        chk("rst_ld_ready", 16'(ld_ready), 16'd0);
        chk("rst_gpio", gpio_out, 16'd0);
        rst = 1'b1;
        tick();
        rd_d("idle_cyc", 16'hFF02, 16'd0);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("load_ready", 16'(ld_ready), 16'd1);
        chk("load_cpu_rst", 16'(cpu_rst), 16'd1);
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1;
            ld_data  = wv[k];
            ld_last  = (k == 2);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("ready_drop", 16'(ld_ready), 16'd0);
        chk("cpu_rst_run1", 16'(cpu_rst), 16'd1);
        tick();
        chk("cpu_rst_run2", 16'(cpu_rst), 16'd0);
        rd_i("mem0", 16'h0000, 16'h1111);
        rd_i("mem1", 16'h0002, 16'h2222);
        rd_i("mem2", 16'h0004, 16'h3333);
        wr_d(16'h0004, 16'hAB00, 2'b01);
        rd_d("lane_even", 16'h0004, 16'hAB33);
        wr_d(16'h0005, 16'h00CD, 2'b10);
        rd_d("lane_odd", 16'h0004, 16'hABCD);
        d_addr = 16'h0004; d_dout = 16'h5555; d_we = 2'b11; d_oe = 1'b1;
        dq.push_back('{"wr_rd_old", 16'hABCD});
        tick();
        d_we = 2'b00; d_oe = 1'b0;
        rd_d("wr_rd_new", 16'h0004, 16'h5555);
        rd_i("alias", 16'h0804, 16'h5555);
        wr_d(16'hFF02, 16'h0000, 2'b11);
        rd_d("cyc0", 16'hFF02, 16'd0);
        rd_d("cyc1", 16'hFF02, 16'd1);
        rd_d("cyc2", 16'hFF02, 16'd2);
        wr_d(16'hFF02, 16'h0000, 2'b11);
        repeat (65535) tick();
        rd_d("cyc_ffff", 16'hFF02, 16'hFFFF);
        rd_d("cyc_wrap", 16'hFF02, 16'h0000);
        wr_d(16'hFF00, 16'h00A5, 2'b11);
        chk("gpio_a5", gpio_out, 16'h00A5);
        rd_i("io_no_mem", 16'h0000, 16'h1111);
        wr_d(16'hFF00, 16'h003C, 2'b10);
        wr_d(16'hFF01, 16'h7700, 2'b01);
        rd_d("gpio_rd", 16'hFF00, 16'h773C);
        wr_d(16'hFF06, 16'hFFFF, 2'b11);
        rd_d("io_other", 16'hFF06, 16'h0000);
        rd_d("gpio_keep", 16'hFF00, 16'h773C);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("reload_cpu_rst", 16'(cpu_rst), 16'd1);
        chk("reload_gpio", gpio_out, 16'h773C);
        rd_d("reload_cyc", 16'hFF02, 16'd0);
        wr_d(16'h0000, 16'hDEAD, 2'b11);
        rd_i("load_no_cpu_wr", 16'h0000, 16'h1111);
        ld_valid = 1'b1;
        ld_data  = 16'h4444;
        tick();
        ld_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_ready", 16'(ld_ready), 16'd0);
        chk("abort_cpu_rst", 16'(cpu_rst), 16'd1);
        chk("abort_gpio", gpio_out, 16'd0);
        rd_i("abort_kept", 16'h0000, 16'h4444);
        rd_i("abort_w1", 16'h0002, 16'h2222);
        s_ld_start = 1'b1;
        tick();
        s_ld_start = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            s_ld_valid = 1'b1;
            s_ld_data  = 16'h5000 + 16'(k);
            if (s_ld_ready) acc++;
            tick();
        end
        s_ld_valid = 1'b0;
        chk("auto_accepts", 16'(acc), 16'd4);
        chk("auto_cpu_rst", 16'(s_cpu_rst), 16'd0);
        s_i_oe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_i_addr = 16'(2 * k);
            #1;
            chk($sformatf("auto_mem%0d", k), s_i_din, 16'h5000 + 16'(k));
        end
        s_i_oe = 1'b0;
        repeat (2) tick();
        chk("queues_drained", 16'(dq.size() + iq.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
